eth_header_decoder: RTL and testbench

//  Downstream of the header capture stage. Takes the packed first-N-byte header and its level-valid,

---
 rtl/eth_parser_pkg.sv | 39 +++
 rtl/eth_ethertype_classifier.sv | 25 ++
 rtl/eth_header_decoder.sv | 156 +++++++++++++++
 tb/tb_eth_header_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_parser_pkg.sv
// Shared Ethernet header types: EtherType constants, classification enum, decoded header payload.
package eth_parser_pkg;

  localparam int unsigned MAC_W       = 48;
  localparam int unsigned ETHERTYPE_W = 16;
  localparam int unsigned TCI_W       = 16;

  localparam logic [ETHERTYPE_W-1:0] ETHERTYPE_IPV4    = 16'h0800;
  localparam logic [ETHERTYPE_W-1:0] ETHERTYPE_ARP     = 16'h0806;
  localparam logic [ETHERTYPE_W-1:0] ETHERTYPE_IPV6    = 16'h86DD;
  localparam logic [ETHERTYPE_W-1:0] ETHERTYPE_VLAN    = 16'h8100;
  // Values strictly below this are 802.3 length fields (LLC frames)
  localparam logic [ETHERTYPE_W-1:0] ETHERTYPE_LLC_MAX = 16'h0600;

  typedef enum logic [2:0] {
    CLS_IPV4  = 3'd0,
    CLS_ARP   = 3'd1,
    CLS_IPV6  = 3'd2,
    CLS_VLAN  = 3'd3,
    CLS_LLC   = 3'd4,
    CLS_OTHER = 3'd5
  } eth_class_e;

  typedef struct packed {
    logic is_bcast;
    logic is_mcast;
    logic vlan_present;
  } eth_flags_t;

  typedef struct packed {
    logic [MAC_W-1:0]       dst_mac;
    logic [MAC_W-1:0]       src_mac;
    logic [ETHERTYPE_W-1:0] ethertype;
    eth_class_e             eth_class;
    eth_flags_t             flags;
    logic [TCI_W-1:0]       vlan_tci;
  } eth_hdr_t;

endpackage

// File: rtl/eth_ethertype_classifier.sv
// Combinational EtherType -> eth_class_e mapping; full 16-bit compares, no masking.
module eth_ethertype_classifier
  import eth_parser_pkg::*;
(
  input  logic [ETHERTYPE_W-1:0] ethertype,
  output eth_class_e             eth_class_c
);

  // Length field below 0x0600 means LLC, otherwise exact-match the known types
  always_comb begin
    eth_class_c = CLS_OTHER;
    if (ethertype < ETHERTYPE_LLC_MAX) begin
      eth_class_c = CLS_LLC;
    end else if (ethertype == ETHERTYPE_IPV4) begin
      eth_class_c = CLS_IPV4;
    end else if (ethertype == ETHERTYPE_ARP) begin
      eth_class_c = CLS_ARP;
    end else if (ethertype == ETHERTYPE_IPV6) begin
      eth_class_c = CLS_IPV6;
    end else if (ethertype == ETHERTYPE_VLAN) begin
      eth_class_c = CLS_VLAN;
    end
  end

endmodule

// File: rtl/eth_header_decoder.sv
// Ethernet header decoder: splits a captured header into fields, classifies it and
// presents one registered result per frame on a valid/ready interface.
// Optional feature: define ETH_VLAN_PARSE_EN to parse a single 802.1Q tag (needs HEADER_BYTES >= 18).
module eth_header_decoder
  import eth_parser_pkg::*;
#(
  parameter int unsigned HEADER_BYTES = 18,
  parameter int unsigned DROP_CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [HEADER_BYTES*8-1:0] header_bytes,
  input  logic                      header_valid,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [MAC_W-1:0]          dst_mac,
  output logic [MAC_W-1:0]          src_mac,
  output logic [ETHERTYPE_W-1:0]    ethertype,
  output eth_class_e                eth_class,
  output logic                      is_bcast,
  output logic                      is_mcast,
  output logic                      vlan_present,
  output logic [TCI_W-1:0]          vlan_tci,
  output logic                      drop_pulse,
  output logic [DROP_CNT_W-1:0]     drop_count
);

  localparam int unsigned HDR_W = HEADER_BYTES * 8;

  typedef enum logic {ST_IDLE, ST_HOLD} state_e;

  state_e                 state;
  logic                   hv_q;
  logic                   armed;
  logic                   cap;
  logic [ETHERTYPE_W-1:0] outer_type;
  logic [ETHERTYPE_W-1:0] final_type;
  logic                   vlan_hit;
  logic [TCI_W-1:0]       tci_w;
  logic [MAC_W-1:0]       dst_w;
  eth_class_e             cls_c;
  eth_hdr_t               dec;
  eth_hdr_t               hdr_q;

  // Parameter sanity and marking of header bytes the decoder never looks at
`ifdef ETH_VLAN_PARSE_EN
  if (HEADER_BYTES < 18) begin : g_bad_hdr
    $error("eth_header_decoder: HEADER_BYTES must be >= 18 with VLAN parsing");
  end
  if (HEADER_BYTES > 18) begin : g_tail
    logic unused_tail;
    assign unused_tail = ^header_bytes[HDR_W-1:144];
  end
`else
  if (HEADER_BYTES < 14) begin : g_bad_hdr
    $error("eth_header_decoder: HEADER_BYTES must be >= 14");
  end
  if (HEADER_BYTES > 14) begin : g_tail
    logic unused_tail;
    assign unused_tail = ^header_bytes[HDR_W-1:112];
  end
`endif

  // Rising edge of header_valid; armed blocks a capture of a level held across reset
  assign cap = header_valid && !hv_q && armed;

  // Outer EtherType and optional single-tag VLAN unwrap
  always_comb begin
    outer_type = {header_bytes[103:96], header_bytes[111:104]};
    final_type = outer_type;
    vlan_hit   = 1'b0;
    tci_w      = '0;
`ifdef ETH_VLAN_PARSE_EN
    if (outer_type == ETHERTYPE_VLAN) begin
      vlan_hit   = 1'b1;
      tci_w      = {header_bytes[119:112], header_bytes[127:120]};
      final_type = {header_bytes[135:128], header_bytes[143:136]};
    end
`endif
  end

  eth_ethertype_classifier u_classifier (
    .ethertype   (final_type),
    .eth_class_c (cls_c)
  );

  // Assemble the decoded header payload (byte 0 is the MSB of each MAC)
  always_comb begin
    dst_w = {header_bytes[7:0],   header_bytes[15:8],  header_bytes[23:16],
             header_bytes[31:24], header_bytes[39:32], header_bytes[47:40]};
    dec                    = '0;
    dec.dst_mac            = dst_w;
    dec.src_mac            = {header_bytes[55:48], header_bytes[63:56], header_bytes[71:64],
                              header_bytes[79:72], header_bytes[87:80], header_bytes[95:88]};
    dec.ethertype          = final_type;
    dec.eth_class          = cls_c;
    dec.flags.is_bcast     = (dst_w == {MAC_W{1'b1}});
    dec.flags.is_mcast     = dst_w[40];
    dec.flags.vlan_present = vlan_hit;
    dec.vlan_tci           = tci_w;
  end

  // Edge detect, IDLE/HOLD handshake FSM, result register and saturating drop counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hv_q       <= 1'b0;
      armed      <= 1'b0;
      m_valid    <= 1'b0;
      hdr_q      <= '0;
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      hv_q       <= header_valid;
      drop_pulse <= 1'b0;
      if (!header_valid) begin
        armed <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (cap) begin
            hdr_q   <= dec;
            m_valid <= 1'b1;
            state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (m_ready) begin
            if (cap) begin
              hdr_q <= dec;
            end else begin
              m_valid <= 1'b0;
              state   <= ST_IDLE;
            end
          end else if (cap) begin
            drop_pulse <= 1'b1;
            if (drop_count != {DROP_CNT_W{1'b1}}) begin
              drop_count <= drop_count + DROP_CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dst_mac      = hdr_q.dst_mac;
  assign src_mac      = hdr_q.src_mac;
  assign ethertype    = hdr_q.ethertype;
  assign eth_class    = hdr_q.eth_class;
  assign is_bcast     = hdr_q.flags.is_bcast;
  assign is_mcast     = hdr_q.flags.is_mcast;
  assign vlan_present = hdr_q.flags.vlan_present;
  assign vlan_tci     = hdr_q.vlan_tci;

endmodule

// File: tb/tb_eth_header_decoder.sv
// Bench for eth_header_decoder: transaction-level model plus per-cycle compare and
// directed literal checks. Drop counter width is reduced so saturation is reachable quickly.
module tb_eth_header_decoder;
  import eth_parser_pkg::*;

  localparam int unsigned HB   = 18;
  localparam int unsigned HW   = HB * 8;
  localparam int unsigned DCW  = 8;
  localparam int          DMAX = (1 << DCW) - 1;

  logic            clk;
  logic            rst_n;
  logic [HW-1:0]   header_bytes;
  logic            header_valid;
  logic            m_valid;
  logic            m_ready;
  logic [47:0]     dst_mac;
  logic [47:0]     src_mac;
  logic [15:0]     ethertype;
  eth_class_e      eth_class;
  logic            is_bcast;
  logic            is_mcast;
  logic            vlan_present;
  logic [15:0]     vlan_tci;
  logic            drop_pulse;
  logic [DCW-1:0]  drop_count;

  eth_header_decoder #(.HEADER_BYTES(HB), .DROP_CNT_W(DCW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .header_bytes (header_bytes),
    .header_valid (header_valid),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .dst_mac      (dst_mac),
    .src_mac      (src_mac),
    .ethertype    (ethertype),
    .eth_class    (eth_class),
    .is_bcast     (is_bcast),
    .is_mcast     (is_mcast),
    .vlan_present (vlan_present),
    .vlan_tci     (vlan_tci),
    .drop_pulse   (drop_pulse),
    .drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] et;
    eth_class_e  cls;
    logic        bc;
    logic        mc;
    logic        vp;
    logic [15:0] tci;
  } exp_t;

  // Build a header from fields: MACs/types written most significant byte first on the wire
  function automatic logic [HW-1:0] mk(input logic [47:0] d, input logic [47:0] s,
                                       input logic [15:0] t, input logic [31:0] x);
    logic [7:0]    by [HB];
    logic [HW-1:0] r;
    for (int k = 0; k < 6; k++) begin
      by[k]     = 8'(d >> (40 - 8 * k));
      by[6 + k] = 8'(s >> (40 - 8 * k));
    end
    by[12] = t[15:8];
    by[13] = t[7:0];
    for (int k = 0; k < 4; k++) by[14 + k] = 8'(x >> (24 - 8 * k));
    r = '0;
    for (int k = 0; k < HB; k++) r = r | (HW'(by[k]) << (8 * k));
    return r;
  endfunction

  function automatic eth_class_e m_class(input int t);
    if (t < 1536)    return CLS_LLC;
    if (t == 'h0800) return CLS_IPV4;
    if (t == 'h0806) return CLS_ARP;
    if (t == 'h86DD) return CLS_IPV6;
    if (t == 'h8100) return CLS_VLAN;
    return CLS_OTHER;
  endfunction

  // Reference decode from the wire bytes using integer arithmetic
  function automatic exp_t m_decode(input logic [HW-1:0] h);
    exp_t e;
    int   b [HB];
    int   outer;
    int   t;
    for (int k = 0; k < HB; k++) begin
      logic [HW-1:0] sh;
      sh   = h >> (8 * k);
      b[k] = int'(sh[7:0]);
    end
    e = '0;
    for (int k = 0; k < 6; k++) begin
      e.dst = (e.dst << 8) | 48'(b[k]);
      e.src = (e.src << 8) | 48'(b[6 + k]);
    end
    outer = b[12] * 256 + b[13];
    t     = outer;
`ifdef ETH_VLAN_PARSE_EN
    if (outer == 'h8100) begin
      e.vp  = 1'b1;
      e.tci = 16'(b[14] * 256 + b[15]);
      t     = b[16] * 256 + b[17];
    end
`endif
    e.et  = 16'(t);
    e.cls = m_class(t);
    e.bc  = (e.dst == 48'hFFFF_FFFF_FFFF);
    e.mc  = (b[0] % 2) == 1;
    return e;
  endfunction

  // Transaction model: one pending result, new frames replace it only when it is being taken
  exp_t e_cur;
  logic e_valid = 1'b0;
  logic e_zero  = 1'b1;
  logic e_pulse = 1'b0;
  int   e_drops = 0;
  logic prev_hv = 1'b0;
  logic seen_low = 1'b0;
  logic live = 1'b0;

  always @(posedge clk) begin
    logic ev;
    logic taken;
    if (!rst_n) begin
      e_cur    = '0;
      e_valid  = 1'b0;
      e_zero   = 1'b1;
      e_pulse  = 1'b0;
      e_drops  = 0;
      prev_hv  = 1'b0;
      seen_low = 1'b0;
      live     = 1'b1;
    end else begin
      ev      = header_valid && !prev_hv && seen_low;
      taken   = e_valid && m_ready;
      e_pulse = 1'b0;
      if (ev && (!e_valid || taken)) begin
        e_cur   = m_decode(header_bytes);
        e_valid = 1'b1;
        e_zero  = 1'b0;
      end else if (ev) begin
        e_pulse = 1'b1;
        if (e_drops < DMAX) e_drops++;
      end else if (taken) begin
        e_valid = 1'b0;
      end
      prev_hv = header_valid;
      if (!header_valid) seen_low = 1'b1;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge
  always @(negedge clk) begin
    if (live) begin
      check("m_valid", 64'(m_valid), 64'(e_valid));
      check("drop_pulse", 64'(drop_pulse), 64'(e_pulse));
      check("drop_count", 64'(drop_count), 64'(e_drops));
      if (e_valid || e_zero) begin
        check("dst_mac", 64'(dst_mac), 64'(e_cur.dst));
        check("src_mac", 64'(src_mac), 64'(e_cur.src));
        check("ethertype", 64'(ethertype), 64'(e_cur.et));
        check("eth_class", 64'(eth_class), 64'(e_cur.cls));
        check("is_bcast", 64'(is_bcast), 64'(e_cur.bc));
        check("is_mcast", 64'(is_mcast), 64'(e_cur.mc));
        check("vlan_present", 64'(vlan_present), 64'(e_cur.vp));
        check("vlan_tci", 64'(vlan_tci), 64'(e_cur.tci));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rise(input logic [HW-1:0] h);
    header_bytes = h;
    header_valid = 1'b1;
    tick(1);
  endtask

  task automatic fall();
    header_valid = 1'b0;
    tick(1);
  endtask

  localparam logic [47:0] SRC = 48'h0011_2233_4455;

  initial begin
    rst_n        = 1'b0;
    header_valid = 1'b0;
    header_bytes = '0;
    m_ready      = 1'b0;
    tick(2);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_dst", 64'(dst_mac), 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Broadcast IPv4, result one clock after the rising edge
    m_ready = 1'b1;
    rise(mk(48'hFFFF_FFFF_FFFF, SRC, 16'h0800, 32'h0));
    check("t1_valid", 64'(m_valid), 64'd1);
    check("t1_class", 64'(eth_class), 64'(CLS_IPV4));
    check("t1_bcast", 64'(is_bcast), 64'd1);
    check("t1_mcast", 64'(is_mcast), 64'd1);
    check("t1_src", 64'(src_mac), 64'h0011_2233_4455);
    fall();
    check("t1_taken", 64'(m_valid), 64'd0);

    // Classification boundaries and multicast
    rise(mk(48'h0200_0000_0001, SRC, 16'h05DC, 32'h0));
    check("t2_llc", 64'(eth_class), 64'(CLS_LLC));
    check("t2_llc_mc", 64'(is_mcast), 64'd0);
    fall();
    rise(mk(48'h0200_0000_0002, SRC, 16'h88CC, 32'h0));
    check("t2_other", 64'(eth_class), 64'(CLS_OTHER));
    fall();
    rise(mk(48'h0100_5E00_0001, SRC, 16'h0806, 32'h0));
    check("t2_mc", 64'(is_mcast), 64'd1);
    check("t2_bc", 64'(is_bcast), 64'd0);
    check("t2_arp", 64'(eth_class), 64'(CLS_ARP));
    fall();
    rise(mk(48'h0200_0000_0003, SRC, 16'h05FF, 32'h0));
    check("t2_05ff", 64'(eth_class), 64'(CLS_LLC));
    fall();
    rise(mk(48'h0200_0000_0004, SRC, 16'h0600, 32'h0));
    check("t2_0600", 64'(eth_class), 64'(CLS_OTHER));
    fall();

    // Accept and capture in the same cycle: no bubble, no drop
    m_ready = 1'b0;
    rise(mk(48'h0200_0000_00AA, SRC, 16'h0800, 32'h0));
    fall();
    m_ready = 1'b1;
    rise(mk(48'h0200_0000_00BB, SRC, 16'h86DD, 32'h0));
    check("t4_valid", 64'(m_valid), 64'd1);
    check("t4_dst", 64'(dst_mac), 64'h0200_0000_00BB);
    check("t4_class", 64'(eth_class), 64'(CLS_IPV6));
    check("t4_drops", 64'(drop_count), 64'd0);
    fall();

    // Stalled consumer: second frame dropped, first result held
    m_ready = 1'b0;
    rise(mk(48'h0200_0000_00C1, SRC, 16'h0800, 32'h0));
    fall();
    rise(mk(48'h0200_0000_00C2, SRC, 16'h0806, 32'h0));
    check("t3_pulse", 64'(drop_pulse), 64'd1);
    check("t3_drops", 64'(drop_count), 64'd1);
    check("t3_dst", 64'(dst_mac), 64'h0200_0000_00C1);
    fall();
    check("t3_pulse_off", 64'(drop_pulse), 64'd0);
    check("t3_held", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    tick(1);
    check("t3_taken", 64'(m_valid), 64'd0);

    // 802.1Q tagged frame, then a tag whose inner type is another tag
    rise(mk(48'h0200_0000_00D1, SRC, 16'h8100, 32'h200A_86DD));
`ifdef ETH_VLAN_PARSE_EN
    check("t5_vp", 64'(vlan_present), 64'd1);
    check("t5_tci", 64'(vlan_tci), 64'h200A);
    check("t5_type", 64'(ethertype), 64'h86DD);
    check("t5_class", 64'(eth_class), 64'(CLS_IPV6));
`else
    check("t5_vp", 64'(vlan_present), 64'd0);
    check("t5_tci", 64'(vlan_tci), 64'h0);
    check("t5_type", 64'(ethertype), 64'h8100);
    check("t5_class", 64'(eth_class), 64'(CLS_VLAN));
`endif
    fall();
    rise(mk(48'h0200_0000_00D2, SRC, 16'h8100, 32'h0001_8100));
    check("t5_inner_class", 64'(eth_class), 64'(CLS_VLAN));
    fall();

    // Reset while holding with header_valid high: no capture until it cycles
    m_ready = 1'b0;
    rise(mk(48'h0200_0000_00E1, SRC, 16'h0800, 32'h0));
    rst_n = 1'b0;
    tick(2);
    check("t6_rst_valid", 64'(m_valid), 64'd0);
    check("t6_rst_dst", 64'(dst_mac), 64'd0);
    check("t6_rst_drops", 64'(drop_count), 64'd0);
    rst_n = 1'b1;
    tick(3);
    check("t6_no_cap", 64'(m_valid), 64'd0);
    fall();
    rise(mk(48'h0200_0000_00E2, SRC, 16'h0800, 32'h0));
    check("t6_cap", 64'(m_valid), 64'd1);
    check("t6_dst", 64'(dst_mac), 64'h0200_0000_00E2);

    // Drive 2^DCW+3 drops against the held result; counter must saturate
    for (int i = 0; i < DMAX + 4; i++) begin
      fall();
      rise(mk(48'h0200_0000_1000 | 48'(i), SRC, 16'h0800, 32'h0));
    end
    check("t6_sat", 64'(drop_count), 64'(DMAX));
    check("t6_sat_dst", 64'(dst_mac), 64'h0200_0000_00E2);
    fall();
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
